// File: rtl/lsu_pkg.sv
// Shared types and RV32I load/store size codes for the read-modify-write LSU.
// Also holds the request legality helpers used at capture time.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        WRITE,
        RESP
    } state_t;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;

    function automatic logic funct3_legal(input logic we, input logic [2:0] f);
        if (we)
            return f inside {SB, SH, SW};
        return f inside {LB, LH, LW, LBU, LHU};
    endfunction

    // Only meaningful for legal codes: bits [1:0] give the access size.
    function automatic logic misaligned(input logic [2:0] f, input logic [1:0] offset);
        case (f[1:0])
            2'b01:   return offset[0];
            2'b10:   return offset != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: extract and extend a loaded lane, or merge a
// sub-word store lane into the word just read from memory.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic [31:0] word,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merged
);

    logic [4:0]  shamt;
    logic [31:0] shifted;
    logic [31:0] mask;

    assign shamt   = {offset, 3'b000};
    assign shifted = word >> shamt;

    always_comb begin
        // NOTE: assign a default before the case so no path leaves the output unassigned (which would infer a latch).
        load_data = word;
        case (funct3)
            LB:      load_data = {{24{shifted[7]}}, shifted[7:0]};
            LH:      load_data = {{16{shifted[15]}}, shifted[15:0]};
            LBU:     load_data = {24'h0, shifted[7:0]};
            LHU:     load_data = {16'h0, shifted[15:0]};
            default: load_data = word;
        endcase
    end

    always_comb begin
        mask   = (funct3 == SB) ? (32'h0000_00FF << shamt) : (32'h0000_FFFF << shamt);
        merged = (word & ~mask) | ((wdata << shamt) & mask);
    end

endmodule

// File: rtl/lsu_rmw.sv
// Load/store unit for a word-only memory: sub-word stores become a
// read-modify-write; all memory strobes and responses are registered.
module lsu_rmw
    import lsu_pkg::*;
#(
    parameter int MEM_WORDS = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_write_data,
    output logic        mem_write,
    output logic        mem_read,
    input  logic [31:0] mem_read_data
);

    state_t      state;
    logic        we_q;
    logic [2:0]  funct3_q;
    logic [1:0]  offset_q;
    logic [31:0] wdata_q;
    logic [31:0] load_data;
    logic [31:0] merged;
    logic        req_err;

    lsu_align u_align (
        .funct3    (funct3_q),
        .offset    (offset_q),
        .word      (mem_read_data),
        .wdata     (wdata_q),
        .load_data (load_data),
        .merged    (merged)
    );

    assign req_ready = (state == IDLE);
    assign req_err   = !funct3_legal(req_we, req_funct3)
                     || misaligned(req_funct3, req_addr[1:0])
                     || ({2'b00, req_addr[31:2]} >= MEM_WORDS);

    // mem_addr doubles as the captured word address; it is zero outside ACCESS/WRITE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            we_q           <= 1'b0;
            funct3_q       <= 3'b000;
            offset_q       <= 2'b00;
            wdata_q        <= 32'h0;
            resp_valid     <= 1'b0;
            resp_err       <= 1'b0;
            resp_rdata     <= 32'h0;
            mem_addr       <= 32'h0;
            mem_write_data <= 32'h0;
            mem_write      <= 1'b0;
            mem_read       <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every update sees pre-edge values.
            case (state)
                IDLE: if (req_valid) begin
                    we_q       <= req_we;
                    funct3_q   <= req_funct3;
                    offset_q   <= req_addr[1:0];
                    wdata_q    <= req_wdata;
                    resp_rdata <= 32'h0;
                    if (req_err) begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b1;
                    end else begin
                        state    <= ACCESS;
                        mem_addr <= {req_addr[31:2], 2'b00};
                        if (req_we && req_funct3 == SW) begin
                            mem_write      <= 1'b1;
                            mem_write_data <= req_wdata;
                        end else begin
                            mem_read <= 1'b1;
                        end
                    end
                end
                ACCESS: begin
                    mem_read       <= 1'b0;
                    mem_write      <= 1'b0;
                    mem_write_data <= 32'h0;
                    if (we_q && funct3_q != SW) begin
                        state          <= WRITE;
                        mem_write      <= 1'b1;
                        mem_write_data <= merged;
                    end else begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        mem_addr   <= 32'h0;
                        if (!we_q)
                            resp_rdata <= load_data;
                    end
                end
                WRITE: begin
                    state          <= RESP;
                    resp_valid     <= 1'b1;
                    mem_write      <= 1'b0;
                    mem_write_data <= 32'h0;
                    mem_addr       <= 32'h0;
                end
                RESP: begin
                    state      <= IDLE;
                    resp_valid <= 1'b0;
                    resp_err   <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_rmw.sv
// Self-checking bench for lsu_rmw: directed scenarios plus random requests
// compared against a byte-addressed little-endian memory model.
module tb_lsu_rmw;
    import lsu_pkg::*;

    localparam int MEM_WORDS = 256;
    localparam int AW        = $clog2(MEM_WORDS);

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_write_data;
    logic        mem_write;
    logic        mem_read;
    logic [31:0] mem_read_data;

    lsu_rmw #(.MEM_WORDS(MEM_WORDS)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_we         (req_we),
        .req_funct3     (req_funct3),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .resp_valid     (resp_valid),
        .resp_rdata     (resp_rdata),
        .resp_err       (resp_err),
        .mem_addr       (mem_addr),
        .mem_write_data (mem_write_data),
        .mem_write      (mem_write),
        .mem_read       (mem_read),
        .mem_read_data  (mem_read_data)
    );

    always #5 clk = ~clk;

    // Downstream word memory: combinational read, synchronous write.
    logic [31:0] mem [MEM_WORDS];
    assign mem_read_data = mem[mem_addr[AW+1:2]];
    always @(posedge clk) if (mem_write) mem[mem_addr[AW+1:2]] <= mem_write_data;

    // Reference model: the same memory viewed as bytes.
    logic [7:0] model [MEM_WORDS*4];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic int unsigned size_of(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic logic model_err(input logic we, input logic [2:0] f3, input logic [31:0] a);
        logic legal;
        legal = we ? (f3 inside {3'b000, 3'b001, 3'b010})
                   : (f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        return !legal || (a % size_of(f3) != 0) || (a / 4 >= MEM_WORDS);
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a);
        logic [31:0] v = 32'h0;
        int unsigned n = size_of(f3);
        for (int i = 0; i < int'(n); i++) v |= 32'(model[a + i]) << (8 * i);
        if (!f3[2] && n < 4 && v[8*n-1]) v |= 32'hFFFF_FFFF << (8 * n);
        return v;
    endfunction

    function automatic logic [31:0] model_word(input int unsigned w);
        return {model[4*w+3], model[4*w+2], model[4*w+1], model[4*w]};
    endfunction

    task automatic model_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
        for (int i = 0; i < int'(size_of(f3)); i++) model[a + i] = wd[8*i +: 8];
    endtask

    task automatic set_word(input int unsigned w, input logic [31:0] v);
        mem[w] = v;
        for (int i = 0; i < 4; i++) model[4*w + i] = v[8*i +: 8];
    endtask

    // One complete request from an IDLE negedge; ends at the negedge where resp_valid is seen.
    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input string tag, output logic [31:0] rdata);
        logic        exp_err, got;
        logic [31:0] exp_rd;
        int          exp_lat, exp_rd_n, exp_wr_n, lat, n_rd, n_wr, n_bad;
        exp_err  = model_err(we, f3, a);
        exp_lat  = exp_err ? 1 : (!we || f3 == SW) ? 2 : 3;
        exp_rd_n = (exp_err || (we && f3 == SW)) ? 0 : 1;
        exp_wr_n = (!exp_err && we) ? 1 : 0;
        exp_rd   = (!exp_err && !we) ? model_load(f3, a) : 32'h0;
        @(negedge clk);
        check({tag, " ready"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
        @(posedge clk);
        lat = 0; got = 1'b0; n_rd = 0; n_wr = 0; n_bad = 0; rdata = 32'h0;
        while (!got && lat < 6) begin
            @(negedge clk);
            lat++;
            if (mem_read) n_rd++;
            if (mem_write) n_wr++;
            if (mem_read && mem_write) n_bad++;
            if ((mem_read || mem_write) && mem_addr != {a[31:2], 2'b00}) n_bad++;
            if (!mem_read && !mem_write && (mem_addr != 0 || mem_write_data != 0)) n_bad++;
            if (resp_valid) begin
                got = 1'b1;
                rdata = resp_rdata;
                check({tag, " err"}, 32'(resp_err), 32'(exp_err));
                check({tag, " rdata"}, resp_rdata, exp_rd);
                req_valid = 1'b0;
            end else begin
                // Junk while busy must be ignored.
                req_valid = 1'($urandom); req_we = 1'($urandom); req_funct3 = 3'($urandom);
                req_addr = $urandom; req_wdata = $urandom;
            end
        end
        req_valid = 1'b0;
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check({tag, " reads"}, 32'(n_rd), 32'(exp_rd_n));
        check({tag, " writes"}, 32'(n_wr), 32'(exp_wr_n));
        check({tag, " bus"}, 32'(n_bad), 32'd0);
        if (!exp_err && we) model_store(f3, a, wd);
        check({tag, " mem word"}, mem[a[AW+1:2]], model_word(int'(a[AW+1:2])));
    endtask

    logic [31:0] rd;
    logic [2:0]  f3_legal [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

    initial begin
        int seen;
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
        req_addr = 32'h0; req_wdata = 32'h0;
        for (int w = 0; w < MEM_WORDS; w++) set_word(w, $urandom);
        set_word(0, 32'h1122_3344);
        set_word(1, 32'h8000_F0FF);
        repeat (3) @(negedge clk);
        check("reset resp_valid", 32'(resp_valid), 32'd0);
        check("reset resp_err", 32'(resp_err), 32'd0);
        check("reset rdata", resp_rdata, 32'h0);
        check("reset strobes", {30'h0, mem_read, mem_write}, 32'h0);
        check("reset ready", 32'(req_ready), 32'd1);
        rst_n = 1'b1;

        // Sub-word store read-modify-write.
        do_req(1'b1, SB, 32'h1, 32'h0000_00AA, "sb 0x1", rd);
        check("sb 0x1 merged", mem[0], 32'h1122_AA44);

        // Sign/zero extension of loaded lanes.
        do_req(1'b0, LB,  32'h4, 32'h0, "lb 0x4", rd);  check("lb value",  rd, 32'hFFFF_FFFF);
        do_req(1'b0, LBU, 32'h4, 32'h0, "lbu 0x4", rd); check("lbu value", rd, 32'h0000_00FF);
        do_req(1'b0, LH,  32'h6, 32'h0, "lh 0x6", rd);  check("lh value",  rd, 32'hFFFF_8000);
        do_req(1'b0, LHU, 32'h6, 32'h0, "lhu 0x6", rd); check("lhu value", rd, 32'h0000_8000);

        // Error cases.
        do_req(1'b0, LW, 32'h2, 32'h0, "lw 0x2 misaligned", rd);
        do_req(1'b1, SH, 32'h3, 32'h1234, "sh 0x3 misaligned", rd);
        do_req(1'b0, 3'b011, 32'h8, 32'h0, "load f3 011", rd);
        do_req(1'b1, SW, 32'h400, 32'h5555_5555, "sw 0x400 range", rd);

        // Back-to-back with req_valid held high.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = SW; req_addr = 32'h3FC; req_wdata = 32'hDEAD_BEEF;
        @(posedge clk);
        @(negedge clk);
        req_we = 1'b0; req_funct3 = LW; req_wdata = 32'h0;
        check("b2b ready in access", 32'(req_ready), 32'd0);
        @(negedge clk);
        check("b2b sw resp", 32'(resp_valid), 32'd1);
        check("b2b ready in resp", 32'(req_ready), 32'd0);
        model_store(SW, 32'h3FC, 32'hDEAD_BEEF);
        @(negedge clk);
        check("b2b ready idle", 32'(req_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        check("b2b lw busy", 32'(req_ready), 32'd0);
        @(negedge clk);
        check("b2b lw resp", 32'(resp_valid), 32'd1);
        check("b2b lw rdata", resp_rdata, 32'hDEAD_BEEF);

        // Reset during the WRITE phase of a halfword store.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = SH; req_addr = 32'h2; req_wdata = 32'h0000_BEEF;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        check("abort read phase", 32'(mem_read), 32'd1);
        @(negedge clk);
        check("abort write phase", 32'(mem_write), 32'd1);
        rst_n = 1'b0;
        #1;
        check("abort strobe cleared", {30'h0, mem_read, mem_write}, 32'h0);
        @(posedge clk);
        #1;
        check("abort word unchanged", mem[0], model_word(0));
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (resp_valid) seen++;
        end
        check("abort no resp", 32'(seen), 32'd0);
        check("abort ready", 32'(req_ready), 32'd1);
        check("abort word final", mem[0], model_word(0));

        // Random traffic.
        for (int t = 0; t < 300; t++) begin
            logic        we;
            logic [2:0]  f3;
            logic [31:0] a;
            we = 1'($urandom);
            f3 = ($urandom_range(0, 9) == 0) ? 3'($urandom) : f3_legal[$urandom_range(0, we ? 2 : 4)];
            a  = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, MEM_WORDS*4 - 1));
            if ($urandom_range(0, 1) == 1 && f3[1:0] != 2'b00) a = a & ~(32'(size_of(f3)) - 1);
            do_req(we, f3, a, $urandom, "rand", rd);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
